alu32: RTL and testbench
========================

Name: alu32

Overview:
- Registered 32-bit arithmetic/logic unit.
- Takes two 32-bit operands and a 3-bit command, and produces a 32-bit result plus carry-out, zero and signed-overflow flags, one clock after the operands are presented.
- Used as the general arithmetic primitive in the datapath, for example for the 32-bit modular additions in the SHA-256 round logic.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is required to be supported and verified.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c  input  3  command select.
- result  output  WIDTH  registered operation result.
- carryout  output  1  registered carry-out (ADD/SUB only).
- zero  output  1  registered flag: high when result is all zeros.
- overflow  output  1  registered two's-complement overflow (ADD/SUB only).

Behaviour:
- Command encoding (c):
  - 0 ADD: a + b
  - 1 SUB: a - b, computed as a + ~b + 1
  - 2 XOR
  - 3 SLT: result = 1 if a < b signed, else 0
  - 4 AND
  - 5 NAND
  - 6 NOR
  - 7 OR
- Latency: all outputs are registered with exactly 1 cycle latency. Operands and command sampled at rising edge N appear on the outputs after edge N. No handshake; a new operation is accepted every cycle.
- Reset:
  - When reset is high at a rising edge: result=0, carryout=0, overflow=0, zero=1.
  - Reset has priority over the operation sampled on that edge.
  - The first valid result appears one edge after the edge at which reset is low.
- Arithmetic:
  - ADD: result = (a+b) mod 2^32. carryout = bit 32 of the unsigned sum.
  - SUB: carryout = bit 32 of a + ~b + 1. This means carryout=1 when a >= b unsigned, including a==b.
  - overflow = 1 when both addends (b inverted for SUB) share a sign and the result sign differs, i.e. carry into MSB XOR carry out of MSB.
  - SLT: result[0] = sign of (a-b) XOR overflow of (a-b); result[31:1] = 0. carryout and overflow are reported as 0.
- Logic ops (XOR, AND, NAND, NOR, OR): bitwise on all 32 bits; carryout=0, overflow=0.
- zero: computed from the same-cycle result value for every command, including logic ops and SLT.
- Boundary conditions:
  - 0xFFFFFFFF + 1: result 0, carryout 1, zero 1, overflow 0.
  - 0x7FFFFFFF + 1: result 0x80000000, overflow 1, carryout 0.
  - SUB 0x80000000 - 1: result 0x7FFFFFFF, overflow 1, carryout 1.
  - SLT 0x80000000 vs 0x00000001: result 1 (signed compare, not unsigned).
- Reset asserted mid-stream: outputs go to reset values on that edge. Normal operation resumes on the next edge with reset low, with no residual state.

Test Plan:
- Reset check: hold reset high for 2 edges -> result=0, carryout=0, overflow=0, zero=1. Release reset with a=2, b=1, c=ADD; after one edge -> result=0x00000003, carryout=0, zero=0, overflow=0.
- ADD boundaries:
  - a=0xFFFFFFFF, b=1 -> result 0, carryout 1, zero 1, overflow 0.
  - a=0x7FFFFFFF, b=1 -> result 0x80000000, overflow 1, carryout 0.
- SUB: each case is checked one cycle after presentation.
  - a=5, b=5 -> result 0, zero 1, carryout 1, overflow 0.
  - a=1, b=2 -> result 0xFFFFFFFF, carryout 0, overflow 0.
  - a=0x80000000, b=1 -> result 0x7FFFFFFF, overflow 1.
- SLT:
  - a=0x80000000, b=1 -> result 1, flags carryout/overflow 0.
  - a=3, b=0xFFFFFFFF -> result 0, zero 1.
  - a=0x7FFFFFFF, b=0x80000000 -> result 0.
- Logic ops with a=0xF0F0FF00, b=0x0FF0F0F0:
  - XOR -> 0xFF000FF0
  - AND -> 0x00F0F000
  - NAND -> 0xFF0F0FFF
  - NOR -> 0x000F000F
  - OR -> 0xFFF0FFF0
  - In every case carryout=0 and overflow=0.
- Back-to-back pipelining:
  - Change a/b/c every cycle across all 8 commands. Each output matches the inputs of the previous edge, with no bubbles.
  - Assert reset for one cycle in the middle: that cycle shows reset values, and the following cycles resume correct results.

Source files
------------

// File: rtl/alu32.sv
// Registered 32-bit ALU: add/sub/slt/logic ops with carry, zero and overflow
// flags, all outputs updated one rising edge after the operands are sampled.
module alu32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       c,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             zero,
  output logic             overflow
);

  typedef enum logic [2:0] {
    CMD_ADD  = 3'd0,
    CMD_SUB  = 3'd1,
    CMD_XOR  = 3'd2,
    CMD_SLT  = 3'd3,
    CMD_AND  = 3'd4,
    CMD_NAND = 3'd5,
    CMD_NOR  = 3'd6,
    CMD_OR   = 3'd7
  } cmd_t;

  cmd_t             cmd;
  logic             sub_op;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             sum_ovf;
  logic [WIDTH-1:0] next_result;
  logic             next_carry;
  logic             next_ovf;

  assign cmd = cmd_t'(c);

  // SUB and SLT share one adder fed with ~b and a carry-in of 1.
  always_comb begin
    sub_op  = (cmd == CMD_SUB) || (cmd == CMD_SLT);
    b_eff   = sub_op ? ~b : b;
    sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};
    sum_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

  always_comb begin
    next_result = '0;
    next_carry  = 1'b0;
    next_ovf    = 1'b0;
    unique case (cmd)
      CMD_ADD, CMD_SUB: begin
        next_result = sum[WIDTH-1:0];
        next_carry  = sum[WIDTH];
        next_ovf    = sum_ovf;
      end
      CMD_SLT:  next_result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ sum_ovf};
      CMD_XOR:  next_result = a ^ b;
      CMD_AND:  next_result = a & b;
      CMD_NAND: next_result = ~(a & b);
      CMD_NOR:  next_result = ~(a | b);
      CMD_OR:   next_result = a | b;
      default:  next_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result   <= '0;
      carryout <= 1'b0;
      zero     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      result   <= next_result;
      carryout <= next_carry;
      zero     <= (next_result == '0);
      overflow <= next_ovf;
    end
  end

endmodule

// File: tb/tb_alu32.sv
// Directed self-checking bench for alu32; each check compares the packed
// tuple {result, carryout, zero, overflow} against a hand-computed value.
module tb_alu32;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic [2:0]  c;
  logic [31:0] result;
  logic        carryout, zero, overflow;

  int checks   = 0;
  int failures = 0;

  alu32 #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .c        (c),
    .result   (result),
    .carryout (carryout),
    .zero     (zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Present operands, clock once and settle just after the edge.
  task automatic step(input logic [31:0] ai, input logic [31:0] bi, input logic [2:0] ci);
    a = ai;
    b = bi;
    c = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(32'd2, 32'd1, 3'd0);
      checks++;
      if ({result, carryout, zero, overflow} !== {32'h0, 3'b010}) begin
        failures++;
        $display("[TB] FAIL reset_hold%0d: got %h %b%b%b expected 00000000 010",
                 i, result, carryout, zero, overflow);
      end
    end
    reset = 1'b0;
    step(32'd2, 32'd1, 3'd0);
    checks++;
    if ({result, carryout, zero, overflow} !== {32'h3, 3'b000}) begin
      failures++;
      $display("[TB] FAIL reset_release: got %h %b%b%b expected 00000003 000",
               result, carryout, zero, overflow);
    end
  endtask

  task automatic test_add();
    logic [31:0] av[2] = '{32'hFFFFFFFF, 32'h7FFFFFFF};
    logic [31:0] bv[2] = '{32'h1, 32'h1};
    logic [34:0] ev[2] = '{{32'h0, 3'b110}, {32'h80000000, 3'b001}};
    for (int i = 0; i < 2; i++) begin
      step(av[i], bv[i], 3'd0);
      checks++;
      if ({result, carryout, zero, overflow} !== ev[i]) begin
        failures++;
        $display("[TB] FAIL add%0d: got %h %b%b%b expected %h %b",
                 i, result, carryout, zero, overflow, ev[i][34:3], ev[i][2:0]);
      end
    end
  endtask

  task automatic test_sub();
    logic [31:0] av[3] = '{32'd5, 32'd1, 32'h80000000};
    logic [31:0] bv[3] = '{32'd5, 32'd2, 32'h1};
    logic [34:0] ev[3] = '{{32'h0, 3'b110}, {32'hFFFFFFFF, 3'b000}, {32'h7FFFFFFF, 3'b101}};
    for (int i = 0; i < 3; i++) begin
      step(av[i], bv[i], 3'd1);
      checks++;
      if ({result, carryout, zero, overflow} !== ev[i]) begin
        failures++;
        $display("[TB] FAIL sub%0d: got %h %b%b%b expected %h %b",
                 i, result, carryout, zero, overflow, ev[i][34:3], ev[i][2:0]);
      end
    end
  endtask

  task automatic test_slt();
    logic [31:0] av[3] = '{32'h80000000, 32'd3, 32'h7FFFFFFF};
    logic [31:0] bv[3] = '{32'h1, 32'hFFFFFFFF, 32'h80000000};
    logic [34:0] ev[3] = '{{32'h1, 3'b000}, {32'h0, 3'b010}, {32'h0, 3'b010}};
    for (int i = 0; i < 3; i++) begin
      step(av[i], bv[i], 3'd3);
      checks++;
      if ({result, carryout, zero, overflow} !== ev[i]) begin
        failures++;
        $display("[TB] FAIL slt%0d: got %h %b%b%b expected %h %b",
                 i, result, carryout, zero, overflow, ev[i][34:3], ev[i][2:0]);
      end
    end
  endtask

  task automatic test_logic();
    logic [2:0]  cv[5] = '{3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [31:0] rv[5] = '{32'hFF000FF0, 32'h00F0F000, 32'hFF0F0FFF, 32'h000F000F, 32'hFFF0FFF0};
    for (int i = 0; i < 5; i++) begin
      step(32'hF0F0FF00, 32'h0FF0F0F0, cv[i]);
      checks++;
      if ({result, carryout, zero, overflow} !== {rv[i], 3'b000}) begin
        failures++;
        $display("[TB] FAIL logic_c%0d: got %h %b%b%b expected %h 000",
                 cv[i], result, carryout, zero, overflow, rv[i]);
      end
    end
  endtask

  // Two passes over all eight commands with no idle cycles; the second pass
  // inserts a one-cycle reset between the fourth and fifth operations.
  task automatic test_back_to_back();
    logic [31:0] av[8] = '{32'd1, 32'd10, 32'hFF, 32'hFFFFFFFE, 32'hC, 32'hFFFFFFFF, 32'h0, 32'h0};
    logic [31:0] bv[8] = '{32'd2, 32'd3, 32'h0F, 32'h1, 32'hA, 32'hFFFFFFFF, 32'h0, 32'h0};
    logic [34:0] ev[8] = '{{32'h3, 3'b000}, {32'h7, 3'b100}, {32'hF0, 3'b000}, {32'h1, 3'b000},
                           {32'h8, 3'b000}, {32'h0, 3'b010}, {32'hFFFFFFFF, 3'b000}, {32'h0, 3'b010}};
    for (int i = 0; i < 16; i++) begin
      if (i == 12) begin
        reset = 1'b1;
        step(32'd7, 32'd9, 3'd0);
        reset = 1'b0;
        checks++;
        if ({result, carryout, zero, overflow} !== {32'h0, 3'b010}) begin
          failures++;
          $display("[TB] FAIL b2b_midreset: got %h %b%b%b expected 00000000 010",
                   result, carryout, zero, overflow);
        end
      end
      step(av[i % 8], bv[i % 8], 3'(i % 8));
      checks++;
      if ({result, carryout, zero, overflow} !== ev[i % 8]) begin
        failures++;
        $display("[TB] FAIL b2b%0d: got %h %b%b%b expected %h %b",
                 i, result, carryout, zero, overflow, ev[i % 8][34:3], ev[i % 8][2:0]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    a = '0;
    b = '0;
    c = '0;
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_logic();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
